// File: rtl/dot_product_ctrl_pkg.sv
// Shared types and sizing helpers for the dot-product read sequencer.
package dot_product_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int SRAM_READ_LATENCY = 1;

  function automatic int acc_w(input int dw, input int aw);
    return 2 * dw + aw;
  endfunction

endpackage

// File: rtl/dot_product_ctrl_mac.sv
// Product register, accumulator and valid pipe tracking SRAM reads.
module dot_product_ctrl_mac
  import dot_product_ctrl_pkg::*;
#(
  parameter int data_width = 8,
  parameter int acc_width  = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  rd_en_i,
  input  logic [data_width-1:0] a_i,
  input  logic [data_width-1:0] b_i,
  output logic [acc_width-1:0]  acc_o,
  output logic                  last_o
);

  localparam int PW = 2 * data_width;
  localparam int L  = SRAM_READ_LATENCY;

  logic [L-1:0]         sram_v_q, sram_v_d;
  logic                 prod_v_q, prod_v_d;
  logic [PW-1:0]        prod_q, prod_d;
  logic [acc_width-1:0] acc_q, acc_d;

  always_comb begin
    sram_v_d    = '0;
    sram_v_d[0] = rd_en_i;
    for (int i = 1; i < L; i++) sram_v_d[i] = sram_v_q[i-1];
    prod_v_d = sram_v_q[L-1];
    prod_d   = PW'(a_i) * PW'(b_i);
    acc_d    = acc_q;
    if (prod_v_q) acc_d = acc_q + acc_width'(prod_q);
    if (clr_i) begin
      sram_v_d = '0;
      prod_v_d = 1'b0;
      acc_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sram_v_q <= '0;
      prod_v_q <= 1'b0;
      prod_q   <= '0;
      acc_q    <= '0;
    end else begin
      sram_v_q <= sram_v_d;
      prod_v_q <= prod_v_d;
      prod_q   <= prod_d;
      acc_q    <= acc_d;
    end
  end

  // Final product sits in the register with nothing behind it.
  assign last_o = prod_v_q & ~(|sram_v_q) & ~rd_en_i;
  assign acc_o  = acc_q;

endmodule

// File: rtl/dot_product_ctrl.sv
// Dot-product read sequencer: FSM, length clamp and shared SRAM address.
module dot_product_ctrl
  import dot_product_ctrl_pkg::*;
#(
  parameter int data_width = 8,
  parameter int addr_width = 4,
  parameter int acc_width  = acc_w(data_width, addr_width)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Start,
  input  logic [addr_width:0]   Length,
  output logic                  Busy,
  output logic                  Done,
  output logic [acc_width-1:0]  Result,
  output logic                  Chip_Select,
  output logic                  En_Read,
  output logic [addr_width-1:0] Read_Addr,
  input  logic [data_width-1:0] A_Data,
  input  logic [data_width-1:0] B_Data
);

  localparam logic [addr_width:0] DEPTH = {1'b1, {addr_width{1'b0}}};

  state_e                state_q, state_d;
  logic [addr_width:0]   n_q, n_d, len_c;
  logic [addr_width-1:0] cnt_q, cnt_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic                  en_q, en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  zl_q, zl_d;
  logic                  clr;
  logic                  mac_last;

  assign len_c = (Length > DEPTH) ? DEPTH : Length;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    addr_d  = '0;
    en_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    zl_d    = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Zero-length run finishes one edge after acceptance.
        if (zl_q) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end else if (Start) begin
          clr    = 1'b1;
          busy_d = 1'b1;
          n_d    = len_c;
          cnt_d  = '0;
          if (len_c == '0) zl_d = 1'b1;
          else state_d = ISSUE;
        end
      end
      ISSUE: begin
        en_d   = 1'b1;
        addr_d = cnt_q;
        cnt_d  = cnt_q + 1'b1;
        if ({1'b0, cnt_q} == n_q - 1'b1) state_d = DRAIN;
      end
      DRAIN: begin
        if (mac_last) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      zl_q    <= zl_d;
    end
  end

  dot_product_ctrl_mac #(
    .data_width(data_width),
    .acc_width (acc_width)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr),
    .rd_en_i(en_q),
    .a_i    (A_Data),
    .b_i    (B_Data),
    .acc_o  (Result),
    .last_o (mac_last)
  );

  assign Busy        = busy_q;
  assign Chip_Select = busy_q;
  assign Done        = done_q;
  assign En_Read     = en_q;
  assign Read_Addr   = addr_q;

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Randomized bench for dot_product_ctrl with SRAM models and a sum reference.
module tb_dot_product_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int ACW = 2 * DW + AW;
  localparam int RD = 1 << AW;

  logic           clk = 1'b0;
  logic           rst;
  logic           Start;
  logic [AW:0]    Length;
  logic           Busy, Done, Chip_Select, En_Read;
  logic [ACW-1:0] Result;
  logic [AW-1:0]  Read_Addr;
  logic [DW-1:0]  A_Data, B_Data;

  logic [DW-1:0] mem_a [RD];
  logic [DW-1:0] mem_b [RD];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dot_product_ctrl #(.data_width(DW), .addr_width(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .Start      (Start),
    .Length     (Length),
    .Busy       (Busy),
    .Done       (Done),
    .Result     (Result),
    .Chip_Select(Chip_Select),
    .En_Read    (En_Read),
    .Read_Addr  (Read_Addr),
    .A_Data     (A_Data),
    .B_Data     (B_Data)
  );

  // Registered-read SRAM pair, zero when not read.
  always_ff @(posedge clk) begin
    if (Chip_Select && En_Read) begin
      A_Data <= mem_a[Read_Addr];
      B_Data <= mem_b[Read_Addr];
    end else begin
      A_Data <= '0;
      B_Data <= '0;
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint ref_sum(input int len);
    longint s = 0;
    int n = (len > RD) ? RD : len;
    for (int i = 0; i < n; i++) s += longint'(mem_a[i]) * longint'(mem_b[i]);
    return s;
  endfunction

  task automatic run(input int len, input bit noise);
    int     n   = (len > RD) ? RD : len;
    int     de  = (n == 0) ? 1 : n + 3;
    longint exp = ref_sum(len);
    int     got = -1;
    int     ens = 0;
    bit     bad_busy = 0;
    bit     bad_seq  = 0;
    longint held;
    @(posedge clk); #1;
    Start  = 1'b1;
    Length = (AW+1)'(len);
    @(posedge clk); #1;
    Start = 1'b0;
    if (noise) Length = (AW+1)'($urandom_range(0, 31));
    chk("busy_at_start", Busy, 1);
    chk("acc_cleared", Result, 0);
    for (int e = 1; e <= 60; e++) begin
      Start = noise && (e == 3 || e == de);
      @(posedge clk); #1;
      if (Busy !== (e < de) || Chip_Select !== Busy) bad_busy = 1;
      if (En_Read) begin
        if (Read_Addr !== AW'(ens)) bad_seq = 1;
        ens++;
      end
      if (Done) begin
        got = e;
        break;
      end
    end
    Start = 1'b0;
    chk("done_edge", got, de);
    chk("result", Result, exp);
    chk("en_read_cycles", ens, n);
    chk("busy_profile", bad_busy, 0);
    chk("addr_sequence", bad_seq, 0);
    held = Result;
    @(posedge clk); #1;
    chk("done_pulse", Done, 0);
    chk("idle_busy", Busy, 0);
    chk("result_hold", Result, held);
  endtask

  initial begin
    int ndone;
    rst    = 1'b1;
    Start  = 1'b0;
    Length = '0;
    for (int i = 0; i < RD; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs",
        {Busy, Done, Chip_Select, En_Read, Read_Addr, Result}, 0);
    rst = 1'b0;

    for (int i = 0; i < RD; i++) begin
      mem_a[i] = DW'(i + 1);
      mem_b[i] = 8'd2;
    end
    run(16, 0);
    run(16, 1);

    for (int i = 0; i < RD; i++) begin
      mem_a[i] = 8'hff;
      mem_b[i] = 8'hff;
    end
    run(16, 0);
    chk("max_sum", Result, 1040400);
    run(0, 0);
    run(20, 0);

    mem_a[0] = 8'd7;
    mem_b[0] = 8'd9;
    run(1, 1);
    chk("len1_sum", Result, 63);

    // Abort a 16-element run with reset sampled at edge 5.
    @(posedge clk); #1;
    Start  = 1'b1;
    Length = 5'd16;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_outs",
        {Busy, Done, Chip_Select, En_Read, Read_Addr, Result}, 0);
    rst = 1'b0;
    ndone = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (Done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run(16, 0);

    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < RD; i++) begin
        mem_a[i] = DW'($urandom);
        mem_b[i] = DW'($urandom);
      end
      run($urandom_range(0, 20), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
